conv_sequencer: RTL
===================

Name: conv_sequencer

Overview:
- Sequences the shared convolution ALU for one MSDAP output sample per channel: left (ch 0) first, then right (ch 1).
- Walks the rj, coefficient and data memories.
- Issues add, subtract and shift commands that realise y(n) = sum over j=1..16 of 2^-j · u_j(n), where u_j is the signed sum of r_j taps x(n-k).
- Started by the top-level controller once per stored input sample; reports completion back to it.

Parameters:
- NUM_RJ, 16, groups per channel (j index 0..15).
- COEFF_DEPTH, 512, coefficient words per channel.
- DATA_DEPTH, 256, circular sample buffer depth per channel.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: new sample written to both channels at sample_idx.
- abort  in  1  synchronous: return to IDLE, zero sample count.
- sample_idx  in  8  buffer index of newest sample x(n).
- rj_addr  out  5  {ch, j}.
- rj_rdata  in  8  r_j, valid 1 cycle after address.
- coeff_addr  out  10  {ch, ptr[8:0]}.
- coeff_rdata  in  9  bit8 = sign (1 = subtract), bits7:0 = k; 1-cycle latency.
- data_addr  out  9  {ch, (sample_idx - k) mod 256}.
- alu_clear  out  1  zero accumulator.
- alu_add  out  1  acc += data_rdata this cycle.
- alu_sub  out  1  acc -= data_rdata this cycle.
- alu_shift  out  1  acc >>>= 1 (arithmetic).
- alu_ch  out  1  channel being processed.
- out_valid  out  1  accumulator holds final y for out_ch.
- out_ch  out  1  channel of out_valid.
- busy  out  1  sequence in progress.
- done  out  1  pulse, both channels complete.
- overrun  out  1  sticky: start while busy.
- cfg_err  out  1  sticky: channel tap total > COEFF_DEPTH.

Behaviour:
- Reset:
  - All outputs 0, state IDLE.
  - Internal ch, j, coeff_ptr and r_cnt are 0.
  - sample_cnt (saturating at DATA_DEPTH) is 0.
- start in IDLE:
  - sample_cnt increments, saturating.
  - Next state CLR, ch = 0, busy = 1 from the next cycle.
- start when not in IDLE: ignored; overrun sets.
- Sticky flags clear only on reset or abort.
- abort has priority over everything except reset. In the next cycle:
  - state is IDLE and sample_cnt is 0.
  - all strobes are 0.
- States (one cycle each unless noted):
  - CLR: alu_clear = 1; rj_addr = {ch, 0}; total = 0.
  - SUM (16 cycles, s = 0..15): total += rj_rdata (10-bit); rj_addr = {ch, s+1} when s < 15.
    - At exit, if total > COEFF_DEPTH: cfg_err = 1 and go to OUT (result is 0).
    - Otherwise coeff_ptr = total, j = 15, go to GRP_RD.
  - GRP_RD: rj_addr = {ch, j}.
  - GRP_LD: r_cnt = rj_rdata. If r_cnt == 0, go to SHIFT; otherwise COEF_RD.
  - COEF_RD: coeff_ptr decrements; coeff_addr = {ch, coeff_ptr - 1}.
  - DAT_RD: latch sign and k; data_addr = {ch, sample_idx - k}.
  - ACC:
    - If k < sample_cnt: alu_add = ~sign, alu_sub = sign. Otherwise neither asserts, because the tap predates the first sample.
    - r_cnt decrements; go to SHIFT if r_cnt reaches 0, else COEF_RD.
  - SHIFT: alu_shift = 1. If j == 0 go to OUT; else j decrements and go to GRP_RD.
  - OUT: out_valid = 1, out_ch = ch.
    - If ch == 0: ch = 1, go to CLR.
    - Otherwise done = 1, busy drops next cycle, go to IDLE.
- alu_ch = ch in every non-IDLE state.
- Strobes are one-hot among alu_clear, alu_add, alu_sub and alu_shift.
- Latency per channel = 66 + 3·R cycles, where R = sum of r_j.
  - L out_valid comes 66 + 3·R_L cycles after the first CLR.
  - done comes 132 + 3·(R_L + R_R) cycles after the first CLR.
- Data address wraps modulo 256. k = 0 addresses x(n).
- Group order is descending j, so each shift halves earlier partial sums. Within a group, taps are read from high address to low.

Test Plan:
- All r_j = 0, start → exactly 16 alu_shift per channel, no alu_add or alu_sub. L out_valid at cycle 66, done at cycle 132.
- Channel 0: r_0 = 1, coeff[0] = 0x000 (k = 0, +), x(n) = 0x0100, sample_cnt = 1 → one alu_add in ACC, then 16 shifts (the j = 0 shift is last). L out_valid at cycle 69.
- sample_idx = 2, coeff k = 5, sign = 1, sample_cnt = 256 → data_addr = {ch, 0xFD}, alu_sub asserted.
- sample_cnt = 3, tap k = 3 → ACC cycle asserts no ALU strobe; r_cnt still decrements.
- Sum of r_j = 600 on ch 0 → cfg_err = 1, L out_valid at cycle 18 with no add, sub or shift; R processes normally.
- start pulsed mid-sequence → overrun = 1, sequence completes unchanged. abort mid-ACC → IDLE next cycle, strobes 0, next start counts sample_cnt = 1.

Source files
------------

// File: rtl/conv_sequencer_if.sv
// Bus bundle between the convolution sequencer and its controller, memories and ALU.
// master is the sequencer side; slave is the surrounding datapath.
interface conv_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] sample_idx;
  logic [4:0] rj_addr;
  logic [7:0] rj_rdata;
  logic [9:0] coeff_addr;
  logic [8:0] coeff_rdata;
  logic [8:0] data_addr;
  logic       alu_clear;
  logic       alu_add;
  logic       alu_sub;
  logic       alu_shift;
  logic       alu_ch;
  logic       out_valid;
  logic       out_ch;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       cfg_err;

  modport master (
    input  start, abort, sample_idx, rj_rdata, coeff_rdata,
    output rj_addr, coeff_addr, data_addr,
    output alu_clear, alu_add, alu_sub, alu_shift, alu_ch,
    output out_valid, out_ch, busy, done, overrun, cfg_err
  );

  modport slave (
    output start, abort, sample_idx, rj_rdata, coeff_rdata,
    input  rj_addr, coeff_addr, data_addr,
    input  alu_clear, alu_add, alu_sub, alu_shift, alu_ch,
    input  out_valid, out_ch, busy, done, overrun, cfg_err
  );
endinterface

// File: rtl/conv_sequencer.sv
// Sequences the shared convolution ALU for one output sample on the left then right channel,
// walking rj, coefficient and data memories and issuing clear/add/sub/shift strobes.
module conv_sequencer #(
  parameter int NUM_RJ      = 16,
  parameter int COEFF_DEPTH = 512,
  parameter int DATA_DEPTH  = 256
) (
  input logic              clk,
  input logic              reset_n,
  conv_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CLR, SUM, GRP_RD, GRP_LD, COEF_RD, DAT_RD, ACC, SHIFT, OUT
  } state_e;

  localparam logic [3:0] LAST_J    = 4'(NUM_RJ - 1);
  localparam logic [9:0] COEFF_MAX = 10'(COEFF_DEPTH);
  localparam logic [8:0] CNT_MAX   = 9'(DATA_DEPTH);

  state_e     state_q, state_d;
  logic       ch_q, ch_d;
  logic [3:0] j_q, j_d;
  logic [9:0] total_q, total_d;
  logic [9:0] coeffPtr_q, coeffPtr_d;
  logic [7:0] rCnt_q, rCnt_d;
  logic       sign_q, sign_d;
  logic [7:0] k_q, k_d;
  logic [8:0] sampleCnt_q, sampleCnt_d;
  logic       overrun_q, overrun_d;
  logic       cfgErr_q, cfgErr_d;

  logic [9:0] totalSum;
  logic [9:0] ptrDec;
  logic [4:0] rjAddr;
  logic [9:0] coeffAddr;
  logic [8:0] dataAddr;
  logic       aluClear, aluAdd, aluSub, aluShift;
  logic       outValid, outCh, doneP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= 1'b0;
      j_q         <= '0;
      total_q     <= '0;
      coeffPtr_q  <= '0;
      rCnt_q      <= '0;
      sign_q      <= 1'b0;
      k_q         <= '0;
      sampleCnt_q <= '0;
      overrun_q   <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      j_q         <= j_d;
      total_q     <= total_d;
      coeffPtr_q  <= coeffPtr_d;
      rCnt_q      <= rCnt_d;
      sign_q      <= sign_d;
      k_q         <= k_d;
      sampleCnt_q <= sampleCnt_d;
      overrun_q   <= overrun_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  // During SUM, j_q doubles as the rj read index s; it is reloaded to the top group on exit.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    j_d         = j_q;
    total_d     = total_q;
    coeffPtr_d  = coeffPtr_q;
    rCnt_d      = rCnt_q;
    sign_d      = sign_q;
    k_d         = k_q;
    sampleCnt_d = sampleCnt_q;
    overrun_d   = overrun_q;
    cfgErr_d    = cfgErr_q;
    rjAddr      = '0;
    coeffAddr   = '0;
    dataAddr    = '0;
    aluClear    = 1'b0;
    aluAdd      = 1'b0;
    aluSub      = 1'b0;
    aluShift    = 1'b0;
    outValid    = 1'b0;
    outCh       = 1'b0;
    doneP       = 1'b0;
    totalSum    = total_q + {2'b00, bus.rj_rdata};
    ptrDec      = coeffPtr_q - 10'd1;

    if (bus.start && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (sampleCnt_q != CNT_MAX) sampleCnt_d = sampleCnt_q + 9'd1;
          ch_d    = 1'b0;
          state_d = CLR;
        end
      end
      CLR: begin
        aluClear = 1'b1;
        rjAddr   = {ch_q, 4'd0};
        total_d  = '0;
        j_d      = '0;
        state_d  = SUM;
      end
      SUM: begin
        total_d = totalSum;
        if (j_q != LAST_J) begin
          rjAddr = {ch_q, j_q + 4'd1};
          j_d    = j_q + 4'd1;
        end else if (totalSum > COEFF_MAX) begin
          cfgErr_d = 1'b1;
          state_d  = OUT;
        end else begin
          coeffPtr_d = totalSum;
          j_d        = LAST_J;
          state_d    = GRP_RD;
        end
      end
      GRP_RD: begin
        rjAddr  = {ch_q, j_q};
        state_d = GRP_LD;
      end
      GRP_LD: begin
        rCnt_d  = bus.rj_rdata;
        state_d = (bus.rj_rdata == 8'd0) ? SHIFT : COEF_RD;
      end
      COEF_RD: begin
        coeffPtr_d = ptrDec;
        coeffAddr  = {ch_q, ptrDec[8:0]};
        state_d    = DAT_RD;
      end
      DAT_RD: begin
        sign_d   = bus.coeff_rdata[8];
        k_d      = bus.coeff_rdata[7:0];
        dataAddr = {ch_q, bus.sample_idx - bus.coeff_rdata[7:0]};
        state_d  = ACC;
      end
      ACC: begin
        // Taps reaching back before the first stored sample contribute nothing.
        if ({1'b0, k_q} < sampleCnt_q) begin
          aluAdd = ~sign_q;
          aluSub = sign_q;
        end
        rCnt_d  = rCnt_q - 8'd1;
        state_d = (rCnt_q == 8'd1) ? SHIFT : COEF_RD;
      end
      SHIFT: begin
        aluShift = 1'b1;
        if (j_q == 4'd0) begin
          state_d = OUT;
        end else begin
          j_d     = j_q - 4'd1;
          state_d = GRP_RD;
        end
      end
      OUT: begin
        outValid = 1'b1;
        outCh    = ch_q;
        if (!ch_q) begin
          ch_d    = 1'b1;
          state_d = CLR;
        end else begin
          doneP   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d     = IDLE;
      ch_d        = 1'b0;
      sampleCnt_d = '0;
      overrun_d   = 1'b0;
      cfgErr_d    = 1'b0;
    end
  end

  assign bus.rj_addr    = rjAddr;
  assign bus.coeff_addr = coeffAddr;
  assign bus.data_addr  = dataAddr;
  assign bus.alu_clear  = aluClear;
  assign bus.alu_add    = aluAdd;
  assign bus.alu_sub    = aluSub;
  assign bus.alu_shift  = aluShift;
  assign bus.alu_ch     = (state_q != IDLE) && ch_q;
  assign bus.out_valid  = outValid;
  assign bus.out_ch     = outCh;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = doneP;
  assign bus.overrun    = overrun_q;
  assign bus.cfg_err    = cfgErr_q;

endmodule
